// File: rtl/conv_layer_input_controller.sv
// Command sequencer for the conv layer input interface: one preload, then alternating
// shift/load commands per output row, with hold-off and a per-command ack watchdog.
//
// state   | meaning
// IDLE    | waiting for start
// ISS_PRE | issue preload command
// WT_PRE  | waiting for preload-finished ack
// ISS_SH  | issue shift command (stalls while hold)
// WT_SH   | waiting for shift-finished ack; reports the completed row
// ISS_LD  | issue row load command (stalls while hold)
// WT_LD   | waiting for load-finished ack
// FIN     | end of pass, pulse done
// ERR     | watchdog expired, parked until reset
module conv_layer_input_controller #(
    parameter int KERNEL_SIZE    = 3,
    parameter int IMAGE_SIZE     = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 hold,
    input  logic [1:0]           ack,
    output logic [1:0]           cmd,
    output logic                 enable,
    output logic                 busy,
    output logic                 row_valid,
    output logic [CNT_WIDTH-1:0] row_idx,
    output logic                 done,
    output logic                 error
);

    localparam int OUT_ROWS = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_ROW = CNT_WIDTH'(OUT_ROWS - 1);
    localparam logic [CNT_WIDTH-1:0] WD_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CMD_IDLE    = 2'd0;
    localparam logic [1:0] CMD_PRELOAD = 2'd1;
    localparam logic [1:0] CMD_SHIFT   = 2'd2;
    localparam logic [1:0] CMD_LOAD    = 2'd3;

    typedef enum logic [3:0] {
        IDLE, ISS_PRE, WT_PRE, ISS_SH, WT_SH, ISS_LD, WT_LD, FIN, ERR
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] row_cnt;
    logic [CNT_WIDTH-1:0] wd_cnt;
    logic [1:0]           exp_ack;
    logic                 ack_hit;
    logic                 wd_expired;

    always_comb begin
        exp_ack = CMD_IDLE;
        case (state)
            WT_PRE:  exp_ack = CMD_PRELOAD;
            WT_SH:   exp_ack = CMD_SHIFT;
            WT_LD:   exp_ack = CMD_LOAD;
            default: exp_ack = CMD_IDLE;
        endcase
    end

    // cmd is still non-idle only in the cycle the command is presented; acks then are ignored
    assign ack_hit    = (exp_ack != CMD_IDLE) && (ack == exp_ack) && (cmd == CMD_IDLE);
    assign wd_expired = (wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_cnt   <= '0;
            wd_cnt    <= '0;
            cmd       <= CMD_IDLE;
            enable    <= 1'b0;
            busy      <= 1'b0;
            row_valid <= 1'b0;
            row_idx   <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            cmd       <= CMD_IDLE;
            row_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    enable <= 1'b0;
                    if (start) begin
                        state  <= ISS_PRE;
                        busy   <= 1'b1;
                        enable <= 1'b1;
                    end
                end
                ISS_PRE: begin
                    cmd    <= CMD_PRELOAD;
                    wd_cnt <= '0;
                    state  <= WT_PRE;
                end
                ISS_SH: begin
                    if (!hold) begin
                        cmd    <= CMD_SHIFT;
                        wd_cnt <= '0;
                        state  <= WT_SH;
                    end
                end
                ISS_LD: begin
                    if (!hold) begin
                        cmd    <= CMD_LOAD;
                        wd_cnt <= '0;
                        state  <= WT_LD;
                    end
                end
                WT_PRE, WT_SH, WT_LD: begin
                    if (ack_hit) begin
                        if (state == WT_SH) begin
                            row_valid <= 1'b1;
                            row_idx   <= row_cnt;
                            if (row_cnt == LAST_ROW) begin
                                state <= FIN;
                            end else begin
                                row_cnt <= row_cnt + 1'b1;
                                state   <= ISS_LD;
                            end
                        end else begin
                            state <= ISS_SH;
                        end
                    end else if (wd_expired) begin
                        state  <= ERR;
                        enable <= 1'b0;
                        busy   <= 1'b0;
                        error  <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    row_cnt <= '0;
                    state   <= IDLE;
                end
                ERR: begin
                    enable <= 1'b0;
                    busy   <= 1'b0;
                    error  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_input_controller.sv
// Directed bench for conv_layer_input_controller: nominal pass, hold-off, wrong acks,
// watchdog timeout, mid-pass reset and ignored starts.
module tb_conv_layer_input_controller;

    logic       clk = 1'b0;
    logic       rst, start, hold;
    logic [1:0] ack;
    logic [1:0] cmd;
    logic       enable, busy, row_valid, done, error;
    logic [7:0] row_idx;

    int total = 0;
    int passes = 0;
    int fails = 0;
    int cmd_count = 0;

    conv_layer_input_controller dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .ack(ack),
        .cmd(cmd), .enable(enable), .busy(busy), .row_valid(row_valid),
        .row_idx(row_idx), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // counts cycles in which a non-idle command was presented
    always @(posedge clk) if (cmd != 2'd0) cmd_count++;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk(tag, {17'd0, cmd, enable, busy, row_valid, row_idx, done, error}, 32'd0);
    endtask

    task automatic wait_cmd(output logic [1:0] c);
        c = 2'd0;
        for (int i = 0; i < 300; i++) begin
            if (cmd != 2'd0) begin
                c = cmd;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic serve(input logic [1:0] code, input int dly, input bit poke);
        logic [1:0] c;
        wait_cmd(c);
        chk("cmd_code", {30'd0, c}, {30'd0, code});
        start = poke;
        @(negedge clk);
        start = 1'b0;
        repeat (dly - 1) @(negedge clk);
        ack = code;
        @(negedge clk);
        ack = 2'd0;
    endtask

    task automatic shift_row(input int idx, input int dly, input bit poke);
        serve(2'd2, dly, poke);
        chk("row_valid", {31'd0, row_valid}, 32'd1);
        chk("row_idx", {24'd0, row_idx}, idx);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [1:0] c;
        int base;
        bit held_ok;

        rst = 1'b1; start = 1'b0; hold = 1'b0; ack = 2'd0;
        repeat (2) @(negedge clk);
        chk_outs_zero("reset_outs");
        rst = 1'b0;
        @(negedge clk);

        // nominal pass, with stray starts during WT_SH and FIN
        base = cmd_count;
        pulse_start();
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_enable", {31'd0, enable}, 32'd1);
        serve(2'd1, 10, 1'b0);
        shift_row(0, 10, 1'b0);
        for (int r = 1; r < 6; r++) begin
            serve(2'd3, 10, 1'b0);
            shift_row(r, 10, r == 2);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_enable_hi", {31'd0, enable}, 32'd1);
        @(negedge clk);
        chk("post_done_enable", {31'd0, enable}, 32'd0);
        chk("post_done_single", {31'd0, done}, 32'd0);
        repeat (5) @(negedge clk);
        chk("no_second_pass", {31'd0, busy}, 32'd0);
        chk("cmd_count_pass", cmd_count - base, 12);

        // hold back-pressure in ISS_LD after row 2
        pulse_start();
        serve(2'd1, 4, 1'b0);
        shift_row(0, 4, 1'b0);
        serve(2'd3, 4, 1'b0);
        shift_row(1, 4, 1'b0);
        serve(2'd3, 4, 1'b0);
        wait_cmd(c);
        chk("hold_sh_cmd", {30'd0, c}, 32'd2);
        repeat (4) @(negedge clk);
        hold = 1'b1;
        ack = 2'd2;
        @(negedge clk);
        ack = 2'd0;
        chk("hold_row_idx", {24'd0, row_idx}, 32'd2);
        held_ok = 1'b1;
        repeat (20) begin
            if (cmd != 2'd0) held_ok = 1'b0;
            @(negedge clk);
        end
        chk("hold_cmd_idle", {31'd0, held_ok}, 32'd1);
        hold = 1'b0;
        @(negedge clk);
        chk("hold_release_cmd", {30'd0, cmd}, 32'd3);
        serve(2'd3, 4, 1'b0);
        for (int r = 3; r < 6; r++) begin
            shift_row(r, 4, 1'b0);
            if (r < 5) serve(2'd3, 4, 1'b0);
        end
        @(negedge clk);
        chk("hold_done", {31'd0, done}, 32'd1);
        repeat (2) @(negedge clk);

        // wrong acks in WT_SH, ack in the issue cycle of a load
        pulse_start();
        serve(2'd1, 5, 1'b0);
        wait_cmd(c);
        chk("wrong_sh_cmd", {30'd0, c}, 32'd2);
        repeat (3) @(negedge clk);
        ack = 2'd3;
        @(negedge clk);
        ack = 2'd1;
        chk("wrong_ack3", {31'd0, row_valid}, 32'd0);
        @(negedge clk);
        ack = 2'd0;
        chk("wrong_ack1", {31'd0, row_valid}, 32'd0);
        ack = 2'd2;
        @(negedge clk);
        ack = 2'd0;
        chk("right_ack_valid", {31'd0, row_valid}, 32'd1);
        chk("right_ack_idx", {24'd0, row_idx}, 32'd0);
        @(negedge clk);
        chk("row_valid_single", {31'd0, row_valid}, 32'd0);
        wait_cmd(c);
        chk("issue_ld_cmd", {30'd0, c}, 32'd3);
        ack = 2'd3;
        @(negedge clk);
        ack = 2'd0;
        held_ok = 1'b1;
        repeat (5) begin
            if (cmd != 2'd0) held_ok = 1'b0;
            @(negedge clk);
        end
        chk("issue_cycle_ack_ignored", {31'd0, held_ok}, 32'd1);
        do_reset();
        chk_outs_zero("wrong_ack_reset");

        // watchdog on a withheld preload ack
        pulse_start();
        wait_cmd(c);
        chk("to_pre_cmd", {30'd0, c}, 32'd1);
        repeat (63) @(negedge clk);
        chk("to_not_yet", {31'd0, error}, 32'd0);
        @(negedge clk);
        chk("to_error", {31'd0, error}, 32'd1);
        chk("to_enable", {31'd0, enable}, 32'd0);
        chk("to_busy", {31'd0, busy}, 32'd0);
        base = cmd_count;
        pulse_start();
        repeat (4) @(negedge clk);
        chk("err_start_busy", {31'd0, busy}, 32'd0);
        chk("err_start_cmds", cmd_count - base, 0);
        chk("err_sticky", {31'd0, error}, 32'd1);
        do_reset();
        chk_outs_zero("err_reset");

        // reset during WT_LD of row 3, then a fresh pass
        pulse_start();
        serve(2'd1, 3, 1'b0);
        shift_row(0, 3, 1'b0);
        serve(2'd3, 3, 1'b0);
        shift_row(1, 3, 1'b0);
        serve(2'd3, 3, 1'b0);
        shift_row(2, 3, 1'b0);
        wait_cmd(c);
        chk("mid_ld_cmd", {30'd0, c}, 32'd3);
        repeat (2) @(negedge clk);
        do_reset();
        chk_outs_zero("mid_reset_outs");
        repeat (2) @(negedge clk);
        chk("mid_no_done", {31'd0, done}, 32'd0);
        pulse_start();
        serve(2'd1, 3, 1'b0);
        shift_row(0, 3, 1'b0);
        do_reset();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/conv_layer_input_controller.md
Name: conv_layer_input_controller

Overview:
- Command initiator for the conv layer input interface: drives its 2-bit cmd and enable, and consumes its 2-bit ack.
- Sequences one full image pass: one preload, then a shift pass per output row, with a row load between consecutive shift passes.
- Sits between the layer top-level scheduler (start/done) and the input interface.
- Adds a hold-off for downstream back-pressure and a per-command watchdog.

Parameters:
- KERNEL_SIZE, 3, kernel edge length.
- IMAGE_SIZE, 8, image edge length. Output rows OUT_ROWS = IMAGE_SIZE-KERNEL_SIZE+1.
- TIMEOUT_CYCLES, 64, maximum cycles waiting for an ack before error.
- CNT_WIDTH, 8, width of the watchdog counter and the row counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  single-cycle request to begin a pass; ignored unless in IDLE.
- hold  input  1  downstream not ready; blocks issue of the next command.
- ack  input  2  from interface: 0 idle, 1 preload fin, 2 shift fin, 3 load fin.
- cmd  output  2  to interface: 0 idle, 1 preload, 2 shift, 3 load.
- enable  output  1  interface enable.
- busy  output  1  pass in progress.
- row_valid  output  1  one-cycle pulse: an output row has completed in the kernel.
- row_idx  output  CNT_WIDTH  index of the row reported by row_valid.
- done  output  1  one-cycle pulse at end of pass.
- error  output  1  sticky watchdog flag.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - Outputs: cmd=0, enable=0, busy=0, row_valid=0, row_idx=0, done=0, error=0.
  - State goes to IDLE and all counters clear.
  - Reset mid-pass aborts immediately; no done pulse.
- All outputs are registered.
- Command issue rule:
  - cmd holds a non-idle code for exactly one cycle, then returns to 0 for the whole wait.
  - Consequence: shift is never presented while the interface is preloading, and load is never re-presented.
- enable=1 from the cycle after start is accepted until the cycle after done; 0 otherwise.
- States:
  - IDLE: start=1 → ISS_PRE. busy rises with the transition.
  - ISS_PRE: cmd=1 for one cycle → WT_PRE.
  - WT_PRE: ack==1 → ISS_SH.
  - ISS_SH: if hold=1, stay with cmd=0. Else cmd=2 for one cycle → WT_SH.
  - WT_SH: ack==2 →
    - row_valid=1 and row_idx=row_cnt in the next cycle;
    - row_cnt increments;
    - if row_cnt (before increment) == OUT_ROWS-1 → FIN, else → ISS_LD.
  - ISS_LD: if hold=1, stay. Else cmd=3 for one cycle → WT_LD.
  - WT_LD: ack==3 → ISS_SH.
  - FIN: done=1 for one cycle, busy=0, row_cnt cleared → IDLE.
  - ERR: cmd=0, enable=0, busy=0, error=1. Leave only by rst.
- Ack handling:
  - In a WT_* state, only the matching ack code completes the wait; every other code is ignored.
  - An ack outside the WT_* states is ignored.
  - An ack arriving in the same cycle the command is issued does not count.
- Watchdog:
  - Counter clears on entry to each WT_* state and increments every cycle in the state.
  - Reaching TIMEOUT_CYCLES with no matching ack → ERR.
  - hold does not pause the watchdog, since hold only acts in ISS_* states.
- start while busy or in ERR: ignored.
- A start coincident with the FIN cycle is ignored; the pass must restart from IDLE.
- Command counts per pass: preload ×1, shift ×OUT_ROWS, load ×(OUT_ROWS-1). With defaults: 1, 6, 5.
- Arithmetic:
  - row_cnt counts 0..OUT_ROWS-1 and never wraps within a pass.
  - Watchdog saturates at TIMEOUT_CYCLES.

Test Plan:
- Nominal pass (defaults): start pulse, model acks after 10 cycles → cmd sequence 1, 2, (3, 2)×5. row_valid pulses with row_idx 0..5. Exactly one done. Then busy=0, enable=0.
- Hold back-pressure: hold=1 for 20 cycles while in ISS_LD after row 2 → cmd stays 0 for those 20 cycles. cmd=3 appears the cycle after hold falls. Row sequence unchanged.
- Wrong ack: in WT_SH, drive ack=3 then ack=1, then ack=2 → only ack=2 completes. row_valid fires once, row_idx=0.
- Timeout: withhold the preload ack for 64 cycles → error=1, enable=0, busy=0. A later start is ignored. rst clears error to 0.
- Reset mid-pass: assert rst during WT_LD of row 3 → next cycle all outputs 0. A fresh start reissues cmd=1 and row_idx restarts at 0.
- Ignored starts: start pulsed during WT_SH and during FIN → no second pass. Exactly 12 non-idle commands per pass.
